// File: rtl/riscv_uc_multicycle.sv
// Multicycle control unit for the RV32I datapath: FETCH/DECODE/EXEC/MEM/WB sequencing,
// memory wait with optional timeout, illegal-opcode trap and retired-instruction counter.
module riscv_uc_multicycle #(
    parameter int SEL_W       = 2,
    parameter int MEM_TIMEOUT = 0,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_i,
    input  logic [6:0]       opcode_i,
    input  logic             branch_i,
    input  logic             mem_ready_i,
    output logic             pc_reset_o,
    output logic             pc_load_o,
    output logic             ir_load_o,
    output logic             mem_re_o,
    output logic             mem_we_o,
    output logic             reg_file_write_o,
    output logic [1:0]       alu_op_o,
    output logic [SEL_W-1:0] sel_alu_a_o,
    output logic [SEL_W-1:0] sel_alu_b_o,
    output logic [SEL_W-1:0] sel_wb_o,
    output logic [SEL_W-1:0] sel_pc_o,
    output logic             sel_addr_o,
    output logic [2:0]       state_o,
    output logic             trap_o,
    output logic [1:0]       trap_cause_o,
    output logic [CNT_W-1:0] retired_o
);
    localparam int TO_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_TRAP   = 3'd6
    } state_t;

    state_t           state_q, state_d;
    logic [TO_W-1:0]  to_q, to_d;
    logic [1:0]       cause_q, cause_d;
    logic [CNT_W-1:0] ret_q;

    logic [1:0] ex_aop, ex_a, ex_b;
    logic [1:0] sel_a, sel_b, sel_wb, sel_pc;
    logic       is_load, is_store, legal, waiting, timeout;

    assign is_load  = (opcode_i == OP_LOAD);
    assign is_store = (opcode_i == OP_STORE);

    // Memory handshake: mem_re/mem_we are held steady while mem_ready_i is low; the
    // transfer completes on the first cycle mem_ready_i is high, and only then do we advance.
    assign waiting = ((state_q == S_FETCH) || (state_q == S_MEM)) && !mem_ready_i;
    assign timeout = (MEM_TIMEOUT != 0) && waiting && (to_q == TO_W'(MEM_TIMEOUT - 1));

    // ALU operand selects chosen in EXEC and held through MEM/WB.
    always_comb begin
        ex_aop = 2'd0;
        ex_a   = 2'd0;
        ex_b   = 2'd0;
        legal  = 1'b1;
        case (opcode_i)
            OP_R:                       ex_aop = 2'b10;
            OP_I:     begin ex_aop = 2'b11; ex_b = 2'd1; end
            OP_LOAD, OP_STORE, OP_JALR: ex_b   = 2'd1;
            OP_LUI:   begin ex_a = 2'd2; ex_b = 2'd1; end
            OP_AUIPC: begin ex_a = 2'd1; ex_b = 2'd1; end
            OP_BR:                      ex_aop = 2'b01;
            OP_JAL:                     ;
            default:                    legal  = 1'b0;
        endcase
    end

    always_comb begin
        state_d          = state_q;
        cause_d          = cause_q;
        pc_reset_o       = 1'b0;
        pc_load_o        = 1'b0;
        ir_load_o        = 1'b0;
        mem_re_o         = 1'b0;
        mem_we_o         = 1'b0;
        reg_file_write_o = 1'b0;
        alu_op_o         = 2'd0;
        sel_a            = 2'd0;
        sel_b            = 2'd0;
        sel_wb           = 2'd0;
        sel_pc           = 2'd0;
        sel_addr_o       = 1'b0;
        case (state_q)
            S_IDLE: begin
                pc_reset_o = 1'b1;
                if (start_i) state_d = S_FETCH;
            end
            S_FETCH: begin
                if (timeout) begin
                    state_d = S_TRAP;
                    cause_d = 2'b10;
                end else begin
                    mem_re_o = 1'b1;
                    if (mem_ready_i) begin
                        ir_load_o = 1'b1;
                        state_d   = S_DECODE;
                    end
                end
            end
            S_DECODE: begin
                if (legal) begin
                    state_d = S_EXEC;
                end else begin
                    state_d = S_TRAP;
                    cause_d = 2'b01;
                end
            end
            S_EXEC: begin
                alu_op_o = ex_aop;
                sel_a    = ex_a;
                sel_b    = ex_b;
                if (opcode_i == OP_BR) begin
                    pc_load_o = 1'b1;
                    sel_pc    = branch_i ? 2'd1 : 2'd0;
                    state_d   = S_FETCH;
                end else if (is_load || is_store) begin
                    state_d = S_MEM;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                if (timeout) begin
                    state_d = S_TRAP;
                    cause_d = 2'b10;
                end else begin
                    alu_op_o   = ex_aop;
                    sel_a      = ex_a;
                    sel_b      = ex_b;
                    sel_addr_o = 1'b1;
                    mem_re_o   = is_load;
                    mem_we_o   = is_store;
                    if (mem_ready_i) begin
                        if (is_load) begin
                            state_d = S_WB;
                        end else begin
                            pc_load_o = 1'b1;
                            state_d   = S_FETCH;
                        end
                    end
                end
            end
            S_WB: begin
                reg_file_write_o = 1'b1;
                pc_load_o        = 1'b1;
                alu_op_o         = ex_aop;
                sel_a            = ex_a;
                sel_b            = ex_b;
                sel_wb           = is_load ? 2'd1 : ((opcode_i == OP_JAL || opcode_i == OP_JALR) ? 2'd2 : 2'd0);
                sel_pc           = (opcode_i == OP_JAL) ? 2'd1 : ((opcode_i == OP_JALR) ? 2'd2 : 2'd0);
                state_d          = S_FETCH;
            end
            S_TRAP:  ;
            default: state_d = S_IDLE;
        endcase
    end

    // The wait counter only runs while stalled in FETCH/MEM, so it is zero on every entry.
    always_comb begin
        to_d = '0;
        if (MEM_TIMEOUT != 0 && waiting) to_d = to_q + TO_W'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            to_q    <= '0;
            cause_q <= 2'b00;
            ret_q   <= '0;
        end else begin
            state_q <= state_d;
            to_q    <= to_d;
            cause_q <= cause_d;
            ret_q   <= ret_q + CNT_W'(pc_load_o);
        end
    end

    assign sel_alu_a_o  = SEL_W'(sel_a);
    assign sel_alu_b_o  = SEL_W'(sel_b);
    assign sel_wb_o     = SEL_W'(sel_wb);
    assign sel_pc_o     = SEL_W'(sel_pc);
    assign state_o      = state_q;
    assign trap_o       = (state_q == S_TRAP);
    assign trap_cause_o = cause_q;
    assign retired_o    = ret_q;
endmodule

// File: doc/riscv_uc_multicycle.md
# riscv_uc_multicycle

Parametrised multicycle control unit for the RV32I datapath. It sequences FETCH/DECODE/EXEC/MEM/WB per instruction and skips stages an opcode does not need. It waits on a memory ready handshake with an optional timeout, decodes the full RV32I base opcode set, traps on illegal opcodes, and counts retired instructions. It sits between the instruction register (opcode, branch flag) and the datapath enables and mux selects.

## Interface
- SEL_W, 2, width of every mux-select output; must be ≥2
- MEM_TIMEOUT, 0, max cycles waiting for mem_ready in FETCH/MEM before trapping; 0 disables timeout
- CNT_W, 32, width of retired-instruction counter
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high
- start  in  1  leave IDLE and begin fetching
- opcode  in  7  instruction[6:0] from instruction register
- branch  in  1  ALU branch-condition true (valid in EXEC)
- mem_ready  in  1  memory completes current read/write this cycle
- pc_reset, pc_load, ir_load, mem_re, mem_we, reg_file_write  out  1  datapath enables
- alu_op  out  2  00 add, 01 branch compare, 10 R-type funct, 11 I-arith funct
- sel_alu_a  out  SEL_W  0 rs1, 1 PC, 2 zero
- sel_alu_b  out  SEL_W  0 rs2, 1 imm
- sel_wb  out  SEL_W  0 ALU, 1 mem data, 2 PC+4
- sel_pc  out  SEL_W  0 PC+4, 1 PC+imm, 2 ALU result
- sel_addr  out  1  memory address: 0 PC, 1 ALU
- state  out  3  current state encoding
- trap  out  1  sticky, in TRAP state
- trap_cause  out  2  01 illegal opcode, 10 memory timeout, 00 none
- retired  out  CNT_W  retired-instruction count

## Operation
- Recognised opcodes: R 0110011, I-arith 0010011, LOAD 0000011, STORE 0100011, BRANCH 1100011, JAL 1101111, JALR 1100111, LUI 0110111, AUIPC 0010111. Anything else is illegal.
- States: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, TRAP=6. Encodings 7 and up go to IDLE next cycle.
- IDLE: pc_reset=1. Goes to FETCH when start=1.
- FETCH: mem_re=1, sel_addr=0. Holds until mem_ready. On the mem_ready cycle ir_load=1 and the next state is DECODE.
- DECODE: no enables. Illegal opcode -> TRAP with cause 01; otherwise -> EXEC.
- EXEC, per opcode:
  - R: a=rs1, b=rs2, alu_op=10.
  - I-arith: a=rs1, b=imm, alu_op=11.
  - LOAD/STORE: a=rs1, b=imm, alu_op=00.
  - LUI: a=zero, b=imm, alu_op=00.
  - AUIPC: a=PC, b=imm, alu_op=00.
  - JALR: a=rs1, b=imm, alu_op=00.
  - JAL: all selects 0.
  - BRANCH: a=rs1, b=rs2, alu_op=01, pc_load=1, sel_pc=branch?1:0, next FETCH.
  - LOAD/STORE go to MEM next; all other non-branch opcodes go to WB.
- MEM: sel_addr=1, ALU selects held from EXEC. LOAD drives mem_re=1; STORE drives mem_we=1. Holds until mem_ready.
  - LOAD -> WB.
  - STORE: pc_load=1, sel_pc=0 on the mem_ready cycle, then -> FETCH.
- WB: reg_file_write=1, pc_load=1, ALU selects held from EXEC, next FETCH.
  - sel_wb: 1 for LOAD, 2 for JAL/JALR, else 0.
  - sel_pc: 1 for JAL, 2 for JALR, else 0.
- TRAP: all enables 0; trap=1; trap_cause held. Only reset exits TRAP.
- Any output not listed for a state/opcode is 0.
- retired increments by 1 on every clock edge where pc_load=1. It wraps modulo 2^CNT_W.
- Timeout counter:
  - Clears on entry to FETCH/MEM and on mem_ready.
  - Increments each waiting cycle.
  - When it reaches MEM_TIMEOUT without mem_ready: -> TRAP with cause 10, no enables that cycle.
  - mem_ready on the same cycle as the limit: completes normally, no trap.

## Timing
- State, timeout counter, retired, trap_cause are registers. Outputs are combinational from state, opcode, branch and mem_ready.
- Reset (async, any time, including mid-wait): state=IDLE, retired=0, trap_cause=0, timeout counter=0. Outputs immediately read pc_reset=1, all others 0.
- Cycles per instruction with zero-wait memory (mem_ready=1 in first cycle):
  - BRANCH 3
  - R, I-arith, LUI, AUIPC, JAL, JALR 4
  - STORE 4
  - LOAD 5
- Each memory wait cycle adds 1.
- mem_re/mem_we stay asserted and constant throughout a wait. ir_load and pc_load pulse exactly one cycle.
- start is ignored outside IDLE.

## Test plan
- Reset, then start=1 with R-type opcode, mem_ready=1 -> states 1,2,3,5,1. reg_file_write and pc_load high only in WB. retired=1 after 4 cycles.
- BRANCH with branch=1 -> pc_load=1, sel_pc=1 in EXEC. Next state FETCH. retired increments. No reg_file_write.
- LOAD with mem_ready low 3 cycles in MEM -> mem_re=1, sel_addr=1 for 4 cycles. Then WB with sel_wb=1. Total 8 cycles.
- JALR -> WB drives sel_wb=2, sel_pc=2. JAL -> sel_pc=1.
- opcode 1111111 -> TRAP after DECODE, trap=1, trap_cause=01. Stays with start toggling. Reset returns to IDLE, trap_cause=0.
- MEM_TIMEOUT=4, mem_ready held 0 in FETCH -> TRAP with cause 10 after 4 waiting cycles. Repeat with mem_ready on the 4th cycle -> DECODE, no trap.
